rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid/alu_ready  input/output  1/1  requester 0 (ALU writeback) handshake.
REQ-006 alu_addr/alu_data  input  ADDR_W/DATA_W  requester 0 destination and value.
REQ-007 mem_valid/mem_ready  input/output  1/1  requester 1 (load writeback) handshake.
REQ-008 mem_addr/mem_data  input  ADDR_W/DATA_W  requester 1 destination and value.
REQ-009 dbg_valid/dbg_ready  input/output  1/1  requester 2 (debug write) handshake.
REQ-010 dbg_addr/dbg_data  input  ADDR_W/DATA_W  requester 2 destination and value.
REQ-011 reg_write_en  output  1  register-file write enable.
REQ-012 write_reg/write_data  output  ADDR_W/DATA_W  register-file write address/data.
REQ-013 last_grant  output  2  index of most recently accepted requester (0/1/2).
REQ-014 wr_count  output  16  saturating count of committed (non-$0) writes.

Function
REQ-015 Block SHALL accept at most one request per cycle; transfer occurs when valid and ready are both high.
REQ-016 ready SHALL be combinational: high only for the single arbitration winner among valid requesters; low for all when none valid.
REQ-017 Arbitration SHALL be round-robin: search starts at (last accepted index + 1) mod 3; pointer advances only on a transfer.
REQ-018 Accepted request SHALL appear on write_reg/write_data with reg_write_en=1 exactly one cycle after the transfer edge (registered outputs, latency 1).
REQ-019 Accepted request with addr==0 SHALL be consumed (ready high) but SHALL produce reg_write_en=0 and not increment wr_count.
REQ-020 With no transfer in a cycle, reg_write_en SHALL be 0 next cycle; write_reg/write_data SHALL hold previous values.
REQ-021 Back-to-back transfers on consecutive cycles SHALL yield consecutive write cycles with no bubble.
REQ-022 wr_count SHALL increment on each committed write and saturate at 16'hFFFF.
REQ-023 A requester holding valid SHALL be granted within 3 cycles (no starvation).
REQ-024 Requester SHALL keep addr/data stable while valid and not ready; block does not check this.

Reset
REQ-025 On reset assertion, reg_write_en, write_reg, write_data, wr_count SHALL clear to 0 immediately, and last_grant SHALL be 2 (so requester 0 has first priority).
REQ-026 A transfer accepted in the cycle reset asserts SHALL be discarded; no write SHALL issue after reset deasserts.
REQ-027 While reset is high all ready outputs SHALL be 0.

Configuration
REQ-028 Macro RF_WB_DEBUG_EN defined: requester 2 participates in round-robin as above.
REQ-029 Macro undefined: dbg_ready SHALL be tied 0, dbg_valid/addr/data ignored, arbitration round-robin over requesters 0 and 1 only; ports remain present.

Structure
REQ-030 Shared package rf_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_WB_REQ=3, and requester index constants REQ_ALU=0, REQ_MEM=1, REQ_DBG=2.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector in, one-hot grant and index out, pointer register internal).

Verification
REQ-032 Reset then alu_valid=1, addr=5, data=32'hDEADBEEF -> alu_ready same cycle; next cycle reg_write_en=1, write_reg=5, write_data=DEADBEEF; wr_count=1.
REQ-033 All three valid continuously for 6 cycles after reset -> grant order ALU,MEM,DBG,ALU,MEM,DBG; 6 consecutive writes; wr_count=6.
REQ-034 mem_valid=1, addr=0, data=32'h1234 -> mem_ready=1; next cycle reg_write_en=0; wr_count unchanged.
REQ-035 Transfer on cycle N, reset pulsed at cycle N+0.5 -> reg_write_en=0 throughout; after release, last_grant=2, wr_count=0.
REQ-036 Build without RF_WB_DEBUG_EN, dbg_valid=1 with alu_valid=1 for 4 cycles -> dbg_ready always 0; four ALU writes only.
REQ-037 Force wr_count to 16'hFFFE, two committed writes -> wr_count reads 16'hFFFF and holds.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: default widths and requester indices.
package rf_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int NUM_WB_REQ = 3;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; search starts one past the last winner.
// Latency: grant is combinational; pointer moves only when something is granted.
// Backpressure: none of its own, a requester simply waits until it wins.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N  = NUM_WB_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] last_idx
);

  logic [IW-1:0] last_q;
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        grant[cand] = 1'b1;
        grant_idx  = cand;
      end
    end
  end

  // Resetting to the highest index gives requester 0 first priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= IW'(N - 1);
    end else if (found) begin
      last_q <= grant_idx;
    end
  end

  assign last_idx = last_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter (ALU, load, debug); debug port active only with RF_WB_DEBUG_EN.
// Latency: one cycle from transfer to reg_write_en; back-to-back transfers give back-to-back writes.
// Backpressure: combinational ready to the round-robin winner only; all readies low during reset.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [1:0]        last_grant,
  output logic [15:0]       wr_count
);

  logic [NUM_WB_REQ-1:0] req;
  logic [NUM_WB_REQ-1:0] grant;
  logic [1:0]            grant_idx;
  logic                  dbg_req;
  logic                  xfer;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_data;

`ifdef RF_WB_DEBUG_EN
  assign dbg_req   = dbg_valid;
  assign dbg_ready = grant[REQ_DBG];
`else
  logic unused_dbg;
  assign dbg_req    = 1'b0;
  assign dbg_ready  = 1'b0;
  assign unused_dbg = ^{dbg_valid, dbg_addr, dbg_data, grant[REQ_DBG]};
`endif

  // Masking requests during reset keeps every ready low and blocks any transfer.
  assign req = reset ? '0 : {dbg_req, mem_valid, alu_valid};

  rr_arbiter #(.N(NUM_WB_REQ), .IW(2)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .last_idx  (last_grant)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign xfer      = |grant;

  always_comb begin
    sel_addr = alu_addr;
    sel_data = alu_data;
    case (grant_idx)
      REQ_MEM: begin
        sel_addr = mem_addr;
        sel_data = mem_data;
      end
      REQ_DBG: begin
        sel_addr = dbg_addr;
        sel_data = dbg_data;
      end
      default: begin
        sel_addr = alu_addr;
        sel_data = alu_data;
      end
    endcase
  end

  // Writes to $0 are consumed but never committed; address/data hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write_en <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      wr_count     <= '0;
    end else if (xfer && (sel_addr != '0)) begin
      reg_write_en <= 1'b1;
      write_reg    <= sel_addr;
      write_data   <= sel_data;
      if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end else begin
      reg_write_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, hand corner sequences, randomized traffic vs model.
module tb_rf_wb_arbiter;

`ifdef RF_WB_DEBUG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, dbg_valid;
  logic        alu_ready, mem_ready, dbg_ready;
  logic [4:0]  alu_addr, mem_addr, dbg_addr;
  logic [31:0] alu_data, mem_data, dbg_data;
  logic        reg_write_en;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  last_grant;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          m_last;
  bit          m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_cnt;

  rf_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .reg_write_en(reg_write_en), .write_reg(write_reg), .write_data(write_data),
    .last_grant(last_grant), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          av; logic [4:0] aa; logic [31:0] ad;
    bit          mv; logic [4:0] ma; logic [31:0] md;
    bit          dv; logic [4:0] da; logic [31:0] dd;
    int          g_en;
    int          g_dis;
  } vec_t;

  vec_t rows[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit av, input bit mv, input bit dv);
    bit v[3];
    v[0] = av; v[1] = mv; v[2] = dv && DBG_EN;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (v[c]) return c;
    end
    return 3;
  endfunction

  task automatic model_reset();
    m_last = 2; m_en = 0; m_reg = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic drive(input vec_t r);
    alu_valid = r.av; alu_addr = r.aa; alu_data = r.ad;
    mem_valid = r.mv; mem_addr = r.ma; mem_data = r.md;
    dbg_valid = r.dv; dbg_addr = r.da; dbg_data = r.dd;
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic cycle(input int eg);
    logic [4:0]  a;
    logic [31:0] d;
    #1;
    chk("alu_ready", alu_ready, (eg == 0));
    chk("mem_ready", mem_ready, (eg == 1));
    chk("dbg_ready", dbg_ready, (eg == 2));
    a = (eg == 0) ? alu_addr : (eg == 1) ? mem_addr : dbg_addr;
    d = (eg == 0) ? alu_data : (eg == 1) ? mem_data : dbg_data;
    @(posedge clock);
    m_en = 0;
    if (eg != 3) begin
      m_last = eg;
      if (a != 0) begin
        m_en = 1; m_reg = a; m_data = d;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    #1;
    chk("reg_write_en", reg_write_en, m_en);
    chk("write_reg", write_reg, m_reg);
    chk("write_data", write_data, m_data);
    chk("wr_count", wr_count, m_cnt);
    chk("last_grant", last_grant, m_last);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1; mem_valid = 1; dbg_valid = 1;
    alu_addr = 5'd9; mem_addr = 5'd9; dbg_addr = 5'd9;
    #1;
    model_reset();
    chk("rst_ready", {alu_ready, mem_ready, dbg_ready}, 3'b000);
    @(posedge clock); #1;
    chk("rst_en", reg_write_en, 0);
    chk("rst_reg", write_reg, 0);
    chk("rst_data", write_data, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_last", last_grant, 2);
    @(negedge clock);
    reset = 1'b0;
    alu_valid = 0; mem_valid = 0; dbg_valid = 0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; mem_valid = 0; dbg_valid = 0;
    alu_addr = '0; mem_addr = '0; dbg_addr = '0;
    alu_data = '0; mem_data = '0; dbg_data = '0;
    model_reset();

    rows[0]  = '{1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 0, 0};
    rows[1]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 3, 3};
    rows[2]  = '{0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, 1, 1};
    rows[3]  = '{1, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 0, 0};
    rows[4]  = '{0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 1, 1};
    rows[5]  = '{0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 2, 0};
    rows[6]  = '{0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 0, 1};
    rows[7]  = '{0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 1, 0};
    rows[8]  = '{0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 5'd3, 32'hC3, 2, 1};
    rows[9]  = '{0, 1, 5'd4, 32'h44,       0, 5'd0, 32'h0,    1, 5'd6, 32'h66, 0, 0};
    rows[10] = '{0, 1, 5'd4, 32'h45,       0, 5'd0, 32'h0,    1, 5'd6, 32'h66, 2, 0};
    rows[11] = '{0, 1, 5'd4, 32'h46,       0, 5'd0, 32'h0,    1, 5'd6, 32'h66, 0, 0};
    rows[12] = '{0, 1, 5'd4, 32'h47,       0, 5'd0, 32'h0,    1, 5'd6, 32'h66, 2, 0};
    rows[13] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 32'h77, 2, 3};

    @(negedge clock);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (rows[i].rst) do_reset();
      drive(rows[i]);
      cycle(DBG_EN ? rows[i].g_en : rows[i].g_dis);
    end

    // Idle cycle: enable drops, address/data hold.
    alu_valid = 0; mem_valid = 0; dbg_valid = 0;
    cycle(3);

    // Reset asserted mid-cycle with a request pending: nothing may commit.
    do_reset();
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h7777;
    #1;
    chk("pre_rst_ready", alu_ready, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ready", alu_ready, 0);
    chk("midrst_en", reg_write_en, 0);
    @(posedge clock); #1;
    chk("midrst_en_after", reg_write_en, 0);
    @(negedge clock);
    reset = 1'b0;
    alu_valid = 0;
    model_reset();
    cycle(3);

    // Saturation of the committed-write counter.
    @(negedge clock);
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    m_cnt = 16'hFFFE;
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h1;
    cycle(pick(1, 0, 0));
    alu_data = 32'h2;
    cycle(pick(1, 0, 0));
    alu_data = 32'h3;
    cycle(pick(1, 0, 0));
    alu_valid = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      alu_valid = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      dbg_valid = 1'($urandom_range(0, 1));
      alu_addr  = 5'($urandom_range(0, 3));
      mem_addr  = 5'($urandom_range(0, 31));
      dbg_addr  = 5'($urandom_range(0, 3));
      alu_data  = $urandom;
      mem_data  = $urandom;
      dbg_data  = $urandom;
      cycle(pick(alu_valid, mem_valid, dbg_valid));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
